// File: rtl/apb_arb_master.sv
// Two-requester APB master with round-robin arbitration.
// Each granted request runs one APB transfer (SETUP, ACCESS) and then returns
// to IDLE, where the requester receives a one-cycle rq_done/rq_err pulse.
// A stalled slave is abandoned after TIMEOUT ACCESS cycles with rq_err set.
module apb_arb_master #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32
) (
   input  logic            PCLK,
   input  logic            PRESET,
   input  logic [1:0]      rq_valid,
   input  logic [1:0]      rq_write,
   input  logic [2*AW-1:0] rq_addr,
   input  logic [2*DW-1:0] rq_wdata,
   output logic [1:0]      rq_done,
   output logic [1:0]      rq_err,
   output logic [DW-1:0]   rq_rdata,
   output logic            PSEL,
   output logic            PENABLE,
   output logic            PWRITE,
   output logic [AW-1:0]   PADDR,
   output logic [DW-1:0]   PWDATA,
   input  logic            PREADY,
   input  logic            PSLVERR,
   input  logic [DW-1:0]   PRDATA
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   // Counter value in the ACCESS cycle that exhausts the timeout budget.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t          state_q,  state_d;
   logic            grant_q,  grant_d;    // current grant, doubles as last-granted
   logic            pwrite_q, pwrite_d;
   logic [AW-1:0]   paddr_q,  paddr_d;
   logic [DW-1:0]   pwdata_q, pwdata_d;
   logic [7:0]      cnt_q,    cnt_d;
   logic [1:0]      done_q,   done_d;
   logic [1:0]      err_q,    err_d;
   logic [DW-1:0]   rdata_q,  rdata_d;

   logic [1:0]      eligible;
   logic            sel;

   // A requester whose done pulse is visible this cycle must not be re-granted.
   assign eligible = rq_valid & ~done_q;

   // Next-state, arbitration and completion logic.
   always_comb begin
      // NOTE: every _d signal gets a default first so no branch can infer a latch.
      state_d  = state_q;
      grant_d  = grant_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      cnt_d    = cnt_q;
      done_d   = 2'b00;
      err_d    = 2'b00;
      rdata_d  = rdata_q;
      sel      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (|eligible) begin
               // On a tie the requester not granted last time wins.
               sel      = (eligible == 2'b11) ? ~grant_q : eligible[1];
               grant_d  = sel;
               pwrite_d = rq_write[sel];
               paddr_d  = sel ? rq_addr[AW +: AW]  : rq_addr[0 +: AW];
               pwdata_d = sel ? rq_wdata[DW +: DW] : rq_wdata[0 +: DW];
               cnt_d    = 8'd0;
               state_d  = S_SETUP;
            end
         end

         S_SETUP: begin
            state_d = S_ACCESS;
         end

         S_ACCESS: begin
            if (PREADY) begin
               // A slave answering on the last allowed cycle still completes normally.
               state_d = S_IDLE;
               done_d  = grant_q ? 2'b10 : 2'b01;
               err_d   = PSLVERR ? done_d : 2'b00;
               rdata_d = pwrite_q ? '0 : PRDATA;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = S_IDLE;
               done_d  = grant_q ? 2'b10 : 2'b01;
               err_d   = done_d;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset; reset aborts any transfer.
   always_ff @(posedge PCLK) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (PRESET) begin
         state_q  <= S_IDLE;
         grant_q  <= 1'b1;          // requester 0 wins the first tie
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         cnt_q    <= 8'd0;
         done_q   <= 2'b00;
         err_q    <= 2'b00;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign PSEL     = (state_q != S_IDLE);
   assign PENABLE  = (state_q == S_ACCESS);
   assign PWRITE   = pwrite_q;
   assign PADDR    = paddr_q;
   assign PWDATA   = pwdata_q;
   assign rq_done  = done_q;
   assign rq_err   = err_q;
   assign rq_rdata = rdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master (TIMEOUT=4) with a small behavioural APB slave.
module tb_apb_arb_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic            PCLK = 1'b0;
   logic            PRESET = 1'b1;
   logic [1:0]      rq_valid = 2'b00;
   logic [1:0]      rq_write = 2'b00;
   logic [2*AW-1:0] rq_addr = '0;
   logic [2*DW-1:0] rq_wdata = '0;
   logic [1:0]      rq_done;
   logic [1:0]      rq_err;
   logic [DW-1:0]   rq_rdata;
   logic            PSEL, PENABLE, PWRITE;
   logic [AW-1:0]   PADDR;
   logic [DW-1:0]   PWDATA;
   logic            PREADY = 1'b0;
   logic            PSLVERR = 1'b0;
   logic [DW-1:0]   PRDATA = '0;

   int total = 0;
   int bad   = 0;

   // Slave configuration, written only by the test tasks.
   int            ready_wait = 0;      // ACCESS cycles with PREADY=0 before PREADY=1
   bit            slverr_cfg = 1'b0;
   bit            force_en   = 1'b0;
   logic [DW-1:0] force_val  = '0;

   // Slave state, written only by the slave process.
   int            acc_k = 0;
   logic [DW-1:0] mem [64];
   bit            mem_valid [64];

   apb_arb_master #(.TIMEOUT(TO), .AW(AW), .DW(DW)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .rq_valid(rq_valid), .rq_write(rq_write), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
      .rq_done(rq_done), .rq_err(rq_err), .rq_rdata(rq_rdata),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
   );

   initial forever #5 PCLK = ~PCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Slave: decides the response for the upcoming edge on each falling edge.
   always @(negedge PCLK) begin
      if (PSEL && PENABLE) begin
         acc_k = acc_k + 1;
         if (acc_k > ready_wait) begin
            PREADY  = 1'b1;
            PSLVERR = slverr_cfg;
            if (PWRITE) begin
               mem[PADDR[5:0]]       = PWDATA;
               mem_valid[PADDR[5:0]] = 1'b1;
            end
            if (force_en)                   PRDATA = force_val;
            else if (mem_valid[PADDR[5:0]]) PRDATA = mem[PADDR[5:0]];
            else                            PRDATA = '0;
         end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = 32'hDEAD_BEEF;
         end
      end else begin
         acc_k   = 0;
         PREADY  = 1'b0;
         PSLVERR = 1'b0;
         PRDATA  = 32'hDEAD_BEEF;
      end
   end

   // Waits (bounded) for a done pulse; reports cycles waited and ACCESS cycles seen.
   task automatic wait_done(input int max_cycles, output int cycles, output int n_acc,
                            output bit timed_out);
      cycles = 0; n_acc = 0; timed_out = 1'b1;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge PCLK);
         cycles++;
         if (PSEL && PENABLE) n_acc++;
         if (rq_done != 2'b00) begin
            timed_out = 1'b0;
            return;
         end
      end
   endtask

   task automatic test_reset();
      PRESET = 1'b1;
      rq_valid = 2'b00;
      repeat (2) @(negedge PCLK);
      total++; if (PSEL !== 1'b0)     begin bad++; $display("FAIL reset_psel: got %0b want 0", PSEL); end
      total++; if (PENABLE !== 1'b0)  begin bad++; $display("FAIL reset_penable: got %0b want 0", PENABLE); end
      total++; if (PWRITE !== 1'b0)   begin bad++; $display("FAIL reset_pwrite: got %0b want 0", PWRITE); end
      total++; if (PADDR !== '0)      begin bad++; $display("FAIL reset_paddr: got %h want 0", PADDR); end
      total++; if (PWDATA !== '0)     begin bad++; $display("FAIL reset_pwdata: got %h want 0", PWDATA); end
      total++; if (rq_done !== 2'b00) begin bad++; $display("FAIL reset_done: got %b want 00", rq_done); end
      total++; if (rq_err !== 2'b00)  begin bad++; $display("FAIL reset_err: got %b want 00", rq_err); end
      total++; if (rq_rdata !== '0)   begin bad++; $display("FAIL reset_rdata: got %h want 0", rq_rdata); end
      PRESET = 1'b0;
   endtask

   task automatic test_write_read();
      int cyc, nacc;
      bit to;
      ready_wait = 0; slverr_cfg = 1'b0; force_en = 1'b0;
      rq_write[0] = 1'b1;
      rq_addr[0 +: AW] = 32'd5;
      rq_wdata[0 +: DW] = 32'hA5A5_0001;
      rq_valid = 2'b01;
      @(negedge PCLK);  // SETUP
      total++; if ({PSEL, PENABLE} !== 2'b10) begin bad++; $display("FAIL wr_setup_ctrl: got %b want 10", {PSEL, PENABLE}); end
      total++; if (PADDR !== 32'd5)           begin bad++; $display("FAIL wr_setup_addr: got %h want 5", PADDR); end
      total++; if (PWRITE !== 1'b1)           begin bad++; $display("FAIL wr_setup_write: got %0b want 1", PWRITE); end
      total++; if (PWDATA !== 32'hA5A5_0001)  begin bad++; $display("FAIL wr_setup_data: got %h want a5a50001", PWDATA); end
      @(negedge PCLK);  // ACCESS
      total++; if ({PSEL, PENABLE} !== 2'b11) begin bad++; $display("FAIL wr_access_ctrl: got %b want 11", {PSEL, PENABLE}); end
      total++; if (PADDR !== 32'd5)           begin bad++; $display("FAIL wr_access_addr: got %h want 5", PADDR); end
      @(negedge PCLK);  // IDLE, completion
      total++; if (rq_done !== 2'b01) begin bad++; $display("FAIL wr_done: got %b want 01", rq_done); end
      total++; if (rq_err !== 2'b00)  begin bad++; $display("FAIL wr_err: got %b want 00", rq_err); end
      total++; if (PSEL !== 1'b0)     begin bad++; $display("FAIL wr_idle_psel: got %0b want 0", PSEL); end
      rq_valid = 2'b00;
      @(negedge PCLK);
      total++; if (rq_done !== 2'b00) begin bad++; $display("FAIL wr_done_pulse: got %b want 00", rq_done); end
      total++; if (PADDR !== 32'd5)   begin bad++; $display("FAIL wr_idle_hold_addr: got %h want 5", PADDR); end
      rq_write[0] = 1'b0;
      rq_valid = 2'b01;
      wait_done(20, cyc, nacc, to);
      rq_valid = 2'b00;
      total++; if (to !== 1'b0)               begin bad++; $display("FAIL rd_timeout_wait: got %0b want 0", to); end
      total++; if (rq_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL rd_data: got %h want a5a50001", rq_rdata); end
      total++; if (rq_err !== 2'b00)          begin bad++; $display("FAIL rd_err: got %b want 00", rq_err); end
      total++; if (nacc !== 1)                begin bad++; $display("FAIL rd_access_cycles: got %0d want 1", nacc); end
      @(negedge PCLK);
   endtask

   task automatic test_round_robin();
      int cyc, nacc;
      bit to;
      logic [1:0] exp_done;
      PRESET = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b0;
      ready_wait = 0;
      rq_write = 2'b00;
      rq_addr = {32'd200, 32'd100};
      rq_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_done = (k % 2 == 0) ? 2'b01 : 2'b10;
         wait_done(20, cyc, nacc, to);
         if (k == 3) rq_valid = 2'b00;
         total++; if (to !== 1'b0)        begin bad++; $display("FAIL rr_wait_%0d: timed out", k); end
         total++; if (rq_done !== exp_done) begin bad++; $display("FAIL rr_grant_%0d: got %b want %b", k, rq_done, exp_done); end
         total++; if (cyc !== 3)          begin bad++; $display("FAIL rr_spacing_%0d: got %0d want 3", k, cyc); end
         total++; if (PSEL !== 1'b0)      begin bad++; $display("FAIL rr_idle_gap_%0d: got %0b want 0", k, PSEL); end
      end
      @(negedge PCLK);
      total++; if (PSEL !== 1'b0) begin bad++; $display("FAIL rr_stop: got %0b want 0", PSEL); end
   endtask

   task automatic test_slverr();
      int cyc, nacc;
      bit to;
      force_en = 1'b1; force_val = 32'h4040_4040; slverr_cfg = 1'b1;
      rq_write[1] = 1'b0;
      rq_addr[AW +: AW] = 32'd40;
      rq_valid = 2'b10;
      wait_done(20, cyc, nacc, to);
      rq_valid = 2'b00;
      total++; if (to !== 1'b0)               begin bad++; $display("FAIL err_wait: timed out"); end
      total++; if (rq_done !== 2'b10)         begin bad++; $display("FAIL err_done: got %b want 10", rq_done); end
      total++; if (rq_err !== 2'b10)          begin bad++; $display("FAIL err_flag: got %b want 10", rq_err); end
      total++; if (rq_rdata !== 32'h4040_4040) begin bad++; $display("FAIL err_rdata: got %h want 40404040", rq_rdata); end
      slverr_cfg = 1'b0; force_en = 1'b0;
      @(negedge PCLK);
      total++; if (rq_err !== 2'b00)          begin bad++; $display("FAIL err_pulse: got %b want 00", rq_err); end
      total++; if (rq_rdata !== 32'h4040_4040) begin bad++; $display("FAIL err_rdata_hold: got %h want 40404040", rq_rdata); end
   endtask

   task automatic test_timeout();
      int cyc, nacc;
      bit to;
      ready_wait = 255;
      rq_write[0] = 1'b0;
      rq_addr[0 +: AW] = 32'd7;
      rq_valid = 2'b01;
      wait_done(30, cyc, nacc, to);
      rq_valid = 2'b00;
      total++; if (to !== 1'b0)        begin bad++; $display("FAIL to_wait: timed out"); end
      total++; if (nacc !== TO)        begin bad++; $display("FAIL to_access_cycles: got %0d want %0d", nacc, TO); end
      total++; if (rq_done !== 2'b01)  begin bad++; $display("FAIL to_done: got %b want 01", rq_done); end
      total++; if (rq_err !== 2'b01)   begin bad++; $display("FAIL to_err: got %b want 01", rq_err); end
      total++; if (rq_rdata !== '0)    begin bad++; $display("FAIL to_rdata: got %h want 0", rq_rdata); end
      total++; if ({PSEL, PENABLE} !== 2'b00) begin bad++; $display("FAIL to_idle: got %b want 00", {PSEL, PENABLE}); end
      ready_wait = 0;
      @(negedge PCLK);
   endtask

   task automatic test_ready_at_timeout();
      int cyc, nacc;
      bit to;
      ready_wait = TO - 1;
      force_en = 1'b1; force_val = 32'h0000_1234; slverr_cfg = 1'b0;
      rq_write[1] = 1'b0;
      rq_addr[AW +: AW] = 32'd12;
      rq_valid = 2'b10;
      wait_done(30, cyc, nacc, to);
      rq_valid = 2'b00;
      total++; if (to !== 1'b0)               begin bad++; $display("FAIL rt_wait: timed out"); end
      total++; if (nacc !== TO)               begin bad++; $display("FAIL rt_access_cycles: got %0d want %0d", nacc, TO); end
      total++; if (rq_done !== 2'b10)         begin bad++; $display("FAIL rt_done: got %b want 10", rq_done); end
      total++; if (rq_err !== 2'b00)          begin bad++; $display("FAIL rt_err: got %b want 00", rq_err); end
      total++; if (rq_rdata !== 32'h0000_1234) begin bad++; $display("FAIL rt_rdata: got %h want 1234", rq_rdata); end
      ready_wait = 0; force_en = 1'b0;
      @(negedge PCLK);
   endtask

   task automatic test_reset_abort();
      int cyc, nacc, seen;
      bit to;
      bit reached;
      ready_wait = 255;
      force_en = 1'b1; force_val = 32'h0000_0099;
      rq_write[0] = 1'b0;
      rq_addr[0 +: AW] = 32'd9;
      rq_valid = 2'b01;
      seen = 0; reached = 1'b0;
      for (int i = 0; i < 10 && !reached; i++) begin
         @(negedge PCLK);
         if (PSEL && PENABLE) seen++;
         if (seen == 2) reached = 1'b1;
      end
      total++; if (reached !== 1'b1) begin bad++; $display("FAIL ab_reach_access2: got %0d access cycles want 2", seen); end
      PRESET = 1'b1;
      @(negedge PCLK);
      total++; if ({PSEL, PENABLE} !== 2'b00) begin bad++; $display("FAIL ab_ctrl: got %b want 00", {PSEL, PENABLE}); end
      total++; if (rq_done !== 2'b00) begin bad++; $display("FAIL ab_done: got %b want 00", rq_done); end
      total++; if (rq_err !== 2'b00)  begin bad++; $display("FAIL ab_err: got %b want 00", rq_err); end
      total++; if (rq_rdata !== '0)   begin bad++; $display("FAIL ab_rdata: got %h want 0", rq_rdata); end
      total++; if (PADDR !== '0)      begin bad++; $display("FAIL ab_paddr: got %h want 0", PADDR); end
      total++; if (PWDATA !== '0)     begin bad++; $display("FAIL ab_pwdata: got %h want 0", PWDATA); end
      PRESET = 1'b0;
      ready_wait = 0;
      @(negedge PCLK);  // re-granted: SETUP
      total++; if ({PSEL, PENABLE} !== 2'b10) begin bad++; $display("FAIL ab_regrant: got %b want 10", {PSEL, PENABLE}); end
      total++; if (PADDR !== 32'd9)   begin bad++; $display("FAIL ab_regrant_addr: got %h want 9", PADDR); end
      wait_done(20, cyc, nacc, to);
      rq_valid = 2'b00;
      total++; if (to !== 1'b0)          begin bad++; $display("FAIL ab_wait: timed out"); end
      total++; if (rq_done !== 2'b01)    begin bad++; $display("FAIL ab_done_after: got %b want 01", rq_done); end
      total++; if (rq_rdata !== 32'h99)  begin bad++; $display("FAIL ab_rdata_after: got %h want 99", rq_rdata); end
      force_en = 1'b0;
      @(negedge PCLK);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_slverr();
      test_timeout();
      test_ready_at_timeout();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter TIMEOUT, 16, max ACCESS cycles waiting for PREADY before forced error completion (range 2..255).
REQ-002 Parameter AW, 32, address width per requester and on PADDR.
REQ-003 Parameter DW, 32, data width of PWDATA/PRDATA/rq_rdata.
REQ-004 PCLK  in  1  single clock; all logic on rising edge.
REQ-005 PRESET  in  1  reset, synchronous, active-high.
REQ-006 rq_valid  in  2  per-requester transfer request, level, held until matching rq_done.
REQ-007 rq_write  in  2  per-requester direction, 1=write, 0=read.
REQ-008 rq_addr  in  2*AW  packed addresses, requester n at [n*AW +: AW].
REQ-009 rq_wdata  in  2*DW  packed write data, requester n at [n*DW +: DW].
REQ-010 rq_done  out  2  one-cycle completion pulse to the granted requester.
REQ-011 rq_err  out  2  error flag, valid with rq_done.
REQ-012 rq_rdata  out  DW  read data, valid with rq_done on reads.
REQ-013 PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
REQ-014 PADDR  out  AW; PWDATA  out  DW  APB address/write data.
REQ-015 PREADY, PSLVERR  in  1 each; PRDATA  in  DW  APB slave response.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS; exactly one active.
REQ-017 IDLE: PSEL=0, PENABLE=0; if any eligible rq_valid bit set, grant one, latch its write/addr/wdata, go SETUP next edge.
REQ-018 Eligible: rq_valid[n]=1 and rq_done[n]=0 in the same cycle (requester just completed is not re-granted in that IDLE cycle).
REQ-019 Arbitration round-robin: single eligible requester wins; both eligible -> requester not granted last wins; after reset requester 0 wins ties.
REQ-020 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from latched request; exactly one cycle, then ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1, PADDR/PWRITE/PWDATA held stable; remain until PREADY=1 or timeout.
REQ-022 ACCESS with PREADY=1: next edge go IDLE, pulse rq_done[grant]=1, rq_err[grant]=PSLVERR, rq_rdata=PRDATA if read else 0.
REQ-023 Timeout counter cleared on SETUP entry, increments each ACCESS cycle with PREADY=0; reaching TIMEOUT -> IDLE, rq_done[grant]=1, rq_err[grant]=1, rq_rdata=0.
REQ-024 PREADY=1 in the cycle the counter reaches TIMEOUT: PREADY wins (normal completion).
REQ-025 Minimum 3 cycles per transfer (SETUP, ACCESS, IDLE); no back-to-back SETUP without IDLE.
REQ-026 rq_valid deasserted mid-transfer: transfer completes on latched values; rq_done still pulsed.
REQ-027 rq_done, rq_err registered; low in every cycle except the completion cycle; rq_rdata holds last value between completions.
REQ-028 PADDR/PWDATA/PWRITE in IDLE hold last latched values (no X).

Reset
REQ-029 PRESET=1 at an edge -> IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rq_done=0, rq_err=0, rq_rdata=0, counter=0, last-grant = requester 1 (so 0 wins first tie).
REQ-030 PRESET during SETUP/ACCESS aborts transfer: no rq_done pulse issued; PSEL low the cycle after reset edge.

Verification
REQ-031 Req0 write addr 5 data 0xA5A5_0001, slave PREADY after 1 ACCESS cycle -> SETUP, ACCESS, rq_done[0]=1, rq_err[0]=0; later read addr 5 -> rq_rdata=0xA5A5_0001.
REQ-032 Both valid from reset, continuous -> grants 0,1,0,1; each rq_done pulse separated by >=3 cycles; no PSEL gap shorter than one IDLE cycle.
REQ-033 Req1 read addr 40, slave PSLVERR=1 with PREADY -> rq_done[1]=1, rq_err[1]=1.
REQ-034 TIMEOUT=4, slave never asserts PREADY -> exactly 4 ACCESS cycles, rq_done=1, rq_err=1, rq_rdata=0, FSM IDLE.
REQ-035 PRESET asserted in ACCESS cycle 2 -> next cycle PSEL=0, rq_done=0, all outputs at REQ-029 values; pending rq_valid re-granted after release.
REQ-036 PREADY=1 on the TIMEOUT-th ACCESS cycle with PRDATA=0x1234 -> rq_err=PSLVERR (0), rq_rdata=0x1234.
